sr_cmd_conditioner: RTL and testbench

//  Upstream command stage for the synchronous SR flip-flop: converts raw, asynchronous set/clear requests into

---
 rtl/sr_cmd_conditioner.sv | 141 ++++++++++++++
 tb/tb_sr_cmd_conditioner.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_conditioner.sv
// Conditions raw asynchronous set/clear requests into clean, mutually exclusive,
// clock-aligned S/R drive pulses for a downstream synchronous SR flip-flop.
module sr_cmd_conditioner #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEB_CYCLES   = 4,
    parameter int CNT_W        = 8,
    parameter int PULSE_LEN    = 1,
    parameter int PRIORITY_CLR = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PW-1:0]    PULSE_LAST = PW'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);

    // Channel index 0 is set, index 1 is clear throughout.
    logic [1:0]             req_s;
    logic [SYNC_STAGES-1:0] sync_r [2];
    logic [CNT_W-1:0]       cnt_r  [2];
    logic [1:0]             deb_r;
    logic [1:0]             deb_d_r;
    logic [1:0]             pend_r;
    logic [1:0]             pend_next_s;
    logic [1:0]             rise_s;
    logic [1:0]             take_s;
    state_t                 state_r;
    state_t                 state_next_s;
    logic                   chan_r;
    logic                   chan_next_s;
    logic [PW-1:0]          pcnt_r;
    logic [PW-1:0]          pcnt_next_s;
    logic                   win_clr_s;
    logic                   s_r;
    logic                   r_r;
    logic                   busy_r;
    logic                   conflict_r;

    assign req_s  = {clr_req, set_req};
    assign rise_s = deb_r & ~deb_d_r;

    // Synchronise and debounce both request channels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                sync_r[i] <= '0;
                cnt_r[i]  <= '0;
            end
            deb_r   <= 2'b00;
            deb_d_r <= 2'b00;
        end else begin
            deb_d_r <= deb_r;
            for (int i = 0; i < 2; i++) begin
                sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], req_s[i]};
                if (sync_r[i][SYNC_STAGES-1] == deb_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (cnt_r[i] == DEB_LAST) begin
                    deb_r[i] <= sync_r[i][SYNC_STAGES-1];
                    cnt_r[i] <= '0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end
            end
        end
    end

    // Arbitration and pulse sequencing; HOLDOFF may hand straight to the next
    // pending request because its own cycle already provides the S/R gap.
    always_comb begin
        state_next_s = state_r;
        chan_next_s  = chan_r;
        pcnt_next_s  = pcnt_r;
        take_s       = 2'b00;
        win_clr_s    = pend_r[1] & (~pend_r[0] | (PRIORITY_CLR != 0));
        case (state_r)
            IDLE, HOLDOFF: begin
                if (|pend_r) begin
                    state_next_s = PULSE;
                    chan_next_s  = win_clr_s;
                    pcnt_next_s  = '0;
                    take_s       = win_clr_s ? 2'b10 : 2'b01;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PULSE: begin
                if (pcnt_r == PULSE_LAST) begin
                    state_next_s = HOLDOFF;
                end else begin
                    pcnt_next_s = pcnt_r + PW'(1);
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        pend_next_s = (pend_r & ~take_s) | rise_s;
    end

    // State, pending flags and registered drive outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            chan_r     <= 1'b0;
            pcnt_r     <= '0;
            pend_r     <= 2'b00;
            s_r        <= 1'b0;
            r_r        <= 1'b0;
            busy_r     <= 1'b0;
            conflict_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            chan_r     <= chan_next_s;
            pcnt_r     <= pcnt_next_s;
            pend_r     <= pend_next_s;
            s_r        <= (state_r == PULSE) && !chan_r;
            r_r        <= (state_r == PULSE) && chan_r;
            busy_r     <= (state_r != IDLE) || (|pend_r);
            conflict_r <= &(pend_next_s & ~pend_r);
        end
    end

    assign S        = s_r;
    assign R        = r_r;
    assign busy     = busy_r;
    assign conflict = conflict_r;

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Scoreboard bench for sr_cmd_conditioner: request episodes are planned by an
// event-level model (ready time, FSM free time, pulse spacing) and checked per cycle.
module tb_sr_cmd_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int PL   = 1;
    localparam int PRI  = 1;
    localparam int MAXC = 8192;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;
    logic S, R, busy, conflict;

    typedef struct {
        int ch;
        int at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   exp_busy [MAXC];
    bit   exp_conf [MAXC];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    sr_cmd_conditioner #(
        .SYNC_STAGES (SYNC),
        .DEB_CYCLES  (DEB),
        .CNT_W       (8),
        .PULSE_LEN   (PL),
        .PRIORITY_CLR(PRI)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .set_req (set_req),
        .clr_req (clr_req),
        .S       (S),
        .R       (R),
        .busy    (busy),
        .conflict(conflict)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    // Monitor: S/R pulses pop the scoreboard; busy/conflict follow the plan every cycle.
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            check("s_and_r_exclusive", int'(S & R), 0);
            check("busy", int'(busy), int'(exp_busy[cyc]));
            check("conflict", int'(conflict), int'(exp_conf[cyc]));
            if (S || R) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", int'(R) * 2 + int'(S), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_channel", R ? 1 : 0, mon_e.ch);
                    check("pulse_cycle", cyc, mon_e.at);
                end
            end
        end
    end

    // A request held high from sampled edge a for l edges is accepted when l >= DEB and
    // becomes pending after edge a+SYNC+DEB. The FSM decides one edge later at the earliest,
    // pulses on the PL following edges, and may decide again PL+1 edges after a decision.
    task automatic plan(input int a_s, input int l_s, input int a_c, input int l_c);
        int   p [2];
        bit   v [2];
        int   fr, m, d, w;
        exp_t t;
        v[0] = (l_s >= DEB);
        v[1] = (l_c >= DEB);
        p[0] = a_s + SYNC + DEB;
        p[1] = a_c + SYNC + DEB;
        if (v[0] && v[1] && p[0] == p[1] && p[0] < MAXC) exp_conf[p[0]] = 1'b1;
        fr = 0;
        while (v[0] || v[1]) begin
            if (v[0] && v[1]) m = (p[0] < p[1]) ? p[0] : p[1];
            else              m = v[0] ? p[0] : p[1];
            d = (fr > m + 1) ? fr : m + 1;
            if (v[0] && v[1] && p[0] + 1 <= d && p[1] + 1 <= d) w = PRI;
            else if (v[0] && p[0] + 1 <= d)                       w = 0;
            else                                                  w = 1;
            for (int j = 0; j < PL; j++) begin
                t.ch = w;
                t.at = d + 1 + j;
                exp_q.push_back(t);
            end
            for (int e = p[w] + 1; e <= d + PL + 1; e++) begin
                if (e < MAXC) exp_busy[e] = 1'b1;
            end
            fr   = d + PL + 1;
            v[w] = 1'b0;
        end
    endtask

    task automatic episode(input int os, input int ls, input int oc, input int lc);
        int c0, len;
        @(negedge clk);
        c0  = cyc;
        plan(c0 + 1 + os, ls, c0 + 1 + oc, lc);
        len = (os + ls > oc + lc) ? os + ls : oc + lc;
        for (int t = 0; t < len; t++) begin
            set_req = (t >= os) && (t < os + ls);
            clr_req = (t >= oc) && (t < oc + lc);
            @(negedge clk);
        end
        set_req = 1'b0;
        clr_req = 1'b0;
        repeat (45) @(negedge clk);
    endtask

    initial begin
        int  ls, lc, os, oc, c0;
        bit  found;
        #1;
        check("reset_S", int'(S), 0);
        check("reset_R", int'(R), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_conflict", int'(conflict), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        episode(0, 12, 0, 0);
        episode(0, 0, 0, 3);
        episode(0, 0, 0, 10);
        episode(0, 12, 0, 12);
        episode(0, DEB - 1, 0, 0);
        episode(0, DEB, 0, 0);
        episode(0, 0, 0, DEB);
        episode(0, 12, 1, 12);
        episode(1, 12, 0, 12);
        episode(2, 10, 0, 10);

        repeat (40) begin
            ls = $urandom_range(0, 14);
            lc = $urandom_range(0, 14);
            os = $urandom_range(0, 2);
            oc = $urandom_range(0, 2);
            if (ls == 0 && lc == 0) ls = DEB;
            episode(os, ls, oc, lc);
        end

        // Asynchronous reset in the middle of a set pulse.
        @(negedge clk);
        c0 = cyc;
        plan(c0 + 1, 40, 0, 0);
        set_req = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (S) found = 1'b1;
        end
        check("s_seen_before_reset", int'(found), 1);
        #2 rst = 1'b0;
        #1;
        check("s_async_drop", int'(S), 0);
        check("r_async_drop", int'(R), 0);
        check("busy_async_drop", int'(busy), 0);
        exp_q.delete();
        for (int e = cyc + 1; e < MAXC; e++) exp_busy[e] = 1'b0;
        set_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
